// File: rtl/theta_apply_if.sv
// theta_apply_if: parity, lane and output valid/ready channels of theta_apply.
interface theta_apply_if #(parameter int W = 64);
  logic           par_valid;
  logic           par_ready;
  logic [5*W-1:0] par_data;
  logic           lane_valid;
  logic           lane_ready;
  logic [W-1:0]   lane_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  modport slave (
    input  par_valid, par_data, lane_valid, lane_data, out_ready,
    output par_ready, lane_ready, out_valid, out_data, out_last
  );
  modport master (
    output par_valid, par_data, lane_valid, lane_data, out_ready,
    input  par_ready, lane_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/theta_apply.sv
// theta_apply: latches C, derives D once, streams 25 lanes as A ^ D[x]; THETA_ERR_EN adds sticky err_o.
module theta_apply #(
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  theta_apply_if.slave  io,
`ifdef THETA_ERR_EN
  output logic          err_o,
`endif
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, LOADD, STREAM} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] c_q [5];
  logic [W-1:0] d_q [5];
  logic [W-1:0] d_d [5];
  logic [4:0]   in_idx_q, out_idx_q;
  logic [2:0]   x_q;
  logic         out_valid_q, out_last_q;
  logic [W-1:0] out_data_q;
  logic         par_ready, lane_ready, lane_hs, out_hs;
  always_comb begin
    state_d    = state_q;
    par_ready  = 1'b0;
    lane_ready = 1'b0;
    case (state_q)
      IDLE: begin
        par_ready = 1'b1;
        state_d   = io.par_valid ? LOADD : IDLE;
      end
      LOADD: state_d = STREAM;
      default: begin
        lane_ready = (in_idx_q < 5'd25) && (!out_valid_q || io.out_ready);
        state_d    = (out_valid_q && io.out_ready && out_last_q) ? IDLE : STREAM;
      end
    endcase
  end
  always_comb
    for (int x = 0; x < 5; x++)
      d_d[x] = c_q[(x+4)%5] ^ {c_q[(x+1)%5][W-2:0], c_q[(x+1)%5][W-1]};
  assign lane_hs       = io.lane_valid && lane_ready;
  assign out_hs        = out_valid_q && io.out_ready;
  assign io.par_ready  = par_ready;
  assign io.lane_ready = lane_ready;
  assign io.out_valid  = out_valid_q;
  assign io.out_data   = out_data_q;
  assign io.out_last   = out_last_q;
  assign busy_o        = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int x = 0; x < 5; x++) begin
        c_q[x] <= '0;
        d_q[x] <= '0;
      end
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && io.par_valid)
        for (int x = 0; x < 5; x++) c_q[x] <= io.par_data[x*W +: W];
      if (state_q == LOADD) begin
        d_q       <= d_d;
        in_idx_q  <= '0;
        out_idx_q <= '0;
        x_q       <= '0;
      end
      if (out_hs) begin
        out_idx_q <= out_idx_q + 5'd1;
        if (!lane_hs || out_last_q) out_valid_q <= 1'b0;
        if (out_last_q) out_last_q <= 1'b0;
      end
      // a lane arriving with an output handshake simply overwrites the register
      if (lane_hs) begin
        out_data_q  <= io.lane_data ^ d_q[x_q];
        out_valid_q <= 1'b1;
        out_last_q  <= in_idx_q == 5'd24;
        in_idx_q    <= in_idx_q + 5'd1;
        x_q         <= (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
      end
    end
  end
`ifdef THETA_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (io.lane_valid && (state_q != STREAM || in_idx_q == 5'd25)) err_q <= 1'b1;
  assign err_o = err_q;
`endif
endmodule

// File: tb/tb_theta_apply.sv
// tb_theta_apply: directed frames for theta_apply with hand-computed D planes.
module tb_theta_apply;
  localparam int W = 64;
  localparam logic [W-1:0] MSB = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] D1 [5] = '{64'd2, 64'd0, 64'd1, 64'd0, 64'd0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef THETA_ERR_EN
  logic err;
`endif
  int errs = 0, checks = 0;
  logic [W-1:0] lanes [25];
  logic [W-1:0] got [25];
  logic         gotlast [25];
  logic [W-1:0] held;
  logic         held_last;
  int nout, first_acc, last_acc, stall_at, stall_len, stall_seen, hold_bad;
  theta_apply_if #(.W(W)) b ();
  theta_apply #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .io(b.slave),
`ifdef THETA_ERR_EN
    .err_o(err),
`endif
    .busy_o(busy)
  );
  always #5 clk = ~clk;

  function automatic logic [5*W-1:0] plane(input logic [W-1:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic run(input logic [5*W-1:0] pd, input int limit);
    int sent, cyc, st;
    sent = 0; cyc = 0; st = 0; nout = 0; hold_bad = 0; first_acc = -1; last_acc = -1;
    @(negedge clk); b.par_valid = 1'b1; b.par_data = pd;
    @(posedge clk);
    @(negedge clk); b.par_valid = 1'b0;
    @(posedge clk);
    while (nout < limit && cyc < 300) begin
      @(negedge clk);
      b.lane_valid = sent < 25;
      b.lane_data  = (sent < 25) ? lanes[sent] : '0;
      b.out_ready  = 1'b1;
      if (b.out_valid && nout == stall_at && st < stall_len) begin
        b.out_ready = 1'b0;
        if (st == 0) begin held = b.out_data; held_last = b.out_last; end
        else if (b.out_data !== held || b.out_last !== held_last) hold_bad++;
        st++;
      end
      #1;
      if (!b.out_ready && (b.lane_ready !== 1'b0 || b.par_ready !== 1'b0)) hold_bad++;
      if (b.lane_valid && b.lane_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        sent++;
      end
      if (b.out_valid && b.out_ready) begin
        got[nout] = b.out_data; gotlast[nout] = b.out_last; nout++;
      end
      cyc++;
      @(posedge clk);
    end
    stall_seen = st;
  endtask

  task automatic test_reset;
    b.par_valid = 0; b.par_data = '0; b.lane_valid = 0; b.lane_data = '0; b.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", b.out_valid); end
    checks++; if (b.out_data !== '0) begin errs++; $display("FAIL reset_out_data got %h exp 0", b.out_data); end
    checks++; if (b.out_last !== 1'b0) begin errs++; $display("FAIL reset_out_last got %b exp 0", b.out_last); end
    checks++; if (b.par_ready !== 1'b1) begin errs++; $display("FAIL reset_par_ready got %b exp 1", b.par_ready); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    b.lane_valid = 1'b1; #1;
    checks++; if (b.lane_ready !== 1'b0) begin errs++; $display("FAIL idle_lane_ready got %b exp 0", b.lane_ready); end
    b.lane_valid = 1'b0;
  endtask

  task automatic test_zero_c;
    for (int i = 0; i < 25; i++) lanes[i] = W'(i);
    stall_at = -1; stall_len = 0;
    run(plane(0, 0, 0, 0, 0), 25);
    checks++; if (nout !== 25) begin errs++; $display("FAIL zero_count got %0d exp 25", nout); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (got[i] !== W'(i)) begin errs++; $display("FAIL zero_data[%0d] got %h exp %h", i, got[i], W'(i)); end
      checks++; if (gotlast[i] !== (i == 24)) begin errs++; $display("FAIL zero_last[%0d] got %b exp %b", i, gotlast[i], i == 24); end
    end
    checks++; if (first_acc !== 0 || last_acc - first_acc + 1 !== 25) begin errs++; $display("FAIL full_rate got first %0d span %0d exp 0 25", first_acc, last_acc - first_acc + 1); end
    #1;
    checks++; if (b.par_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL zero_idle got par_ready %b busy %b exp 1 0", b.par_ready, busy); end
  endtask

  task automatic test_c1;
    logic [W-1:0] e [5];
    e = '{64'hFD, 64'hFF, 64'hFE, 64'hFF, 64'hFF};
    for (int i = 0; i < 25; i++) lanes[i] = 64'hFF;
    stall_at = -1;
    run(plane(0, 1, 0, 0, 0), 25);
    checks++; if (nout !== 25) begin errs++; $display("FAIL c1_count got %0d exp 25", nout); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (got[i] !== e[i%5]) begin errs++; $display("FAIL c1_data[%0d] got %h exp %h", i, got[i], e[i%5]); end
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] e [5];
    e = '{MSB, 64'd0, 64'd0, 64'd1, 64'd0};
    for (int i = 0; i < 25; i++) lanes[i] = '0;
    stall_at = -1;
    run(plane(0, 0, 0, 0, MSB), 25);
    checks++; if (nout !== 25) begin errs++; $display("FAIL wrap_count got %0d exp 25", nout); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (got[i] !== e[i%5]) begin errs++; $display("FAIL wrap_data[%0d] got %h exp %h", i, got[i], e[i%5]); end
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
    stall_at = 7; stall_len = 3;
    run(plane(0, 1, 0, 0, 0), 25);
    stall_at = -1;
    #1;
    checks++; if (b.par_ready !== 1'b1) begin errs++; $display("FAIL bp_par_ready got %b exp 1", b.par_ready); end
    checks++; if (nout !== 25) begin errs++; $display("FAIL bp_count got %0d exp 25", nout); end
    checks++; if (stall_seen !== 3 || hold_bad !== 0) begin errs++; $display("FAIL bp_hold got stalls %0d bad %0d exp 3 0", stall_seen, hold_bad); end
    checks++; if (held !== (lanes[7] ^ 64'd1)) begin errs++; $display("FAIL bp_held got %h exp %h", held, lanes[7] ^ 64'd1); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (got[i] !== (lanes[i] ^ D1[i%5])) begin errs++; $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], lanes[i] ^ D1[i%5]); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 25; i++) lanes[i] = W'(i + 100);
    stall_at = -1;
    run(plane(0, 0, 0, 0, 0), 10);
    checks++; if (nout !== 10) begin errs++; $display("FAIL mid_count got %0d exp 10", nout); end
    @(negedge clk); b.lane_valid = 1'b0; rst_n = 1'b0; #1;
    checks++; if (b.out_valid !== 1'b0 || busy !== 1'b0 || b.par_ready !== 1'b1) begin errs++; $display("FAIL mid_reset got valid %b busy %b par_ready %b exp 0 0 1", b.out_valid, busy, b.par_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 25; i++) lanes[i] = W'(i);
    run(plane(0, 1, 0, 0, 0), 25);
    checks++; if (nout !== 25) begin errs++; $display("FAIL post_count got %0d exp 25", nout); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (got[i] !== (W'(i) ^ D1[i%5]) || gotlast[i] !== (i == 24)) begin errs++; $display("FAIL post_data[%0d] got %h/%b exp %h/%b", i, got[i], gotlast[i], W'(i) ^ D1[i%5], i == 24); end
    end
  endtask

`ifdef THETA_ERR_EN
  task automatic test_err;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL err_reset got %b exp 0", err); end
    @(negedge clk); rst_n = 1'b1; b.lane_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errs++; $display("FAIL err_set got %b exp 1", err); end
    b.lane_valid = 1'b0;
    for (int i = 0; i < 25; i++) lanes[i] = W'(i);
    stall_at = -1;
    run(plane(0, 0, 0, 0, 0), 25);
    #1;
    checks++; if (err !== 1'b1 || nout !== 25) begin errs++; $display("FAIL err_sticky got err %b outputs %0d exp 1 25", err, nout); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", err); end
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_zero_c;
    test_c1;
    test_wrap;
    test_backpressure;
    test_reset_mid;
`ifdef THETA_ERR_EN
    test_err;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
